// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and small decode helpers. ROB_WIDTH is the global
// define shared with the rest of the core; a default is supplied here so
// that the unit also builds on its own.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

package muldiv_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Remainder flavours return the remainder instead of the quotient.
  function automatic logic isRemOp(input logic [2:0] f);
    return (f == OP_REM) || (f == OP_REMU);
  endfunction

  // Signed divide flavours: operands are two's complement.
  function automatic logic isSignedDivOp(input logic [2:0] f);
    return (f == OP_DIV) || (f == OP_REM);
  endfunction

  // Quotient-producing divide flavours.
  function automatic logic isQuotOp(input logic [2:0] f);
    return (f == OP_DIV) || (f == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div.sv
// div_iter
// Iterative restoring divider on unsigned magnitudes. The start cycle loads
// the operands and already performs the first iteration, so after start plus
// XLEN-1 enabled steps the quotient/remainder are final and done_o is high.
// done_o stays high (and the results stay put) until the next start.
// Ports:
//   clk_in, rst_in  clock, asynchronous active-high reset
//   start_i         load dividend/divisor and run iteration 1
//   step_i          run one more iteration (ignored once done)
//   dividend_i      dividend magnitude
//   divisor_i       divisor magnitude (never zero when started)
//   done_o          all XLEN iterations complete
//   quotient_o      unsigned quotient
//   remainder_o     unsigned remainder
module div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] curRem, curQuo;
  logic [XLEN:0]   shifted, trial;

  assign done_o      = (cnt_q == CW'(XLEN));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // The quotient register doubles as the dividend shift register: each
  // iteration shifts its MSB into the partial remainder and the new
  // quotient bit into its LSB. The partial remainder is always below the
  // divisor, so one extra bit is enough to detect a failed subtraction.
  always_comb begin
    curRem  = start_i ? '0 : rem_q;
    curQuo  = start_i ? dividend_i : quo_q;
    dvs_d   = start_i ? divisor_i : dvs_q;
    shifted = {curRem, curQuo[XLEN-1]};
    trial   = shifted - {1'b0, dvs_d};
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    if (start_i || (step_i && !done_o)) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {curQuo[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {curQuo[XLEN-2:0], 1'b0};
      end
      cnt_d = start_i ? CW'(1) : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// RV32M execution unit. One op at a time is accepted from the reservation
// station; multiplies complete MUL_STAGES edges after acceptance, divides
// and remainders go through div_iter and a sign-fix cycle, and the
// divide-by-zero / signed-overflow cases complete one edge after acceptance.
// Results leave as a single-cycle pulse on the ALU result-bus protocol.
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   rdy_in             global ready; low freezes everything
//   clear              misprediction flush (qualified by rdy_in)
//   issue_valid/ready  issue handshake (ready = unit idle)
//   lhs, rhs, op       operands and funct3
//   rob_dep            destination ROB tag
//   ready, rob_id, value  result pulse; tag/value are zero when ready is low
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ROB_WIDTH  = `ROB_WIDTH,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [XLEN-1:0]      lhs,
  input  logic [XLEN-1:0]      rhs,
  input  logic [2:0]           op,
  input  logic [ROB_WIDTH-1:0] rob_dep,
  output logic                 ready,
  output logic [ROB_WIDTH-1:0] rob_id,
  output logic [XLEN-1:0]      value
);

  localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e                state_q;
  logic [ROB_WIDTH-1:0]  rob_q;
  logic [XLEN-1:0]       lhs_q, rhs_q, res_q;
  logic [1:0]            mulOp_q;
  logic [MCW-1:0]        mulCnt_q;
  logic                  divRem_q, negQ_q, negR_q;

  logic                  accept;
  logic                  lhsNeg, rhsNeg;
  logic [XLEN-1:0]       lhsMag, rhsMag;
  logic                  divZero, divOvf;
  logic [XLEN-1:0]       specialVal;
  logic                  divStart, divStep, divDone;
  logic [XLEN-1:0]       divQuo, divRemRaw, divResult;
  logic                  aSign, bSign;
  logic [2*XLEN-1:0]     aWide, bWide, prod;
  logic [XLEN-1:0]       mulResult;

  assign issue_ready = (state_q == ST_IDLE);
  assign accept      = rdy_in && !clear && issue_valid && issue_ready;

  // Issue-side decode: operand magnitudes for the divider and the results
  // of the two special cases, which bypass the divider entirely.
  always_comb begin
    lhsNeg  = isSignedDivOp(op) && lhs[XLEN-1];
    rhsNeg  = isSignedDivOp(op) && rhs[XLEN-1];
    lhsMag  = lhsNeg ? -lhs : lhs;
    rhsMag  = rhsNeg ? -rhs : rhs;
    divZero = (rhs == '0);
    divOvf  = isSignedDivOp(op) && (lhs == INT_MIN) && (rhs == '1);
    if (divZero) begin
      specialVal = isQuotOp(op) ? '1 : lhs;
    end else begin
      specialVal = isRemOp(op) ? '0 : lhs;
    end
  end

  assign divStart = accept && op[2] && !divZero && !divOvf;
  assign divStep  = rdy_in && !clear && (state_q == ST_DIV);

  div_iter #(.XLEN(XLEN)) uDiv (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_i     (divStart),
    .step_i      (divStep),
    .dividend_i  (lhsMag),
    .divisor_i   (rhsMag),
    .done_o      (divDone),
    .quotient_o  (divQuo),
    .remainder_o (divRemRaw)
  );

  assign divResult = divRem_q ? (negR_q ? -divRemRaw : divRemRaw)
                              : (negQ_q ? -divQuo : divQuo);

  // Operands are extended by one bit (sign or zero per variant) and then
  // sign-extended to the full product width; the low 2*XLEN bits of that
  // product are exact for every variant.
  always_comb begin
    aSign     = (mulOp_q != OP_MULHU[1:0]) && lhs_q[XLEN-1];
    bSign     = (mulOp_q == OP_MULH[1:0]) && rhs_q[XLEN-1];
    aWide     = {{XLEN{aSign}}, lhs_q};
    bWide     = {{XLEN{bSign}}, rhs_q};
    prod      = aWide * bWide;
    mulResult = (mulOp_q == OP_MUL[1:0]) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Control FSM with registered result outputs. Completion edges return to
  // IDLE so a new op can be accepted during the result pulse; clear wins
  // over completion and over acceptance.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      ready    <= 1'b0;
      rob_id   <= '0;
      value    <= '0;
      rob_q    <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      res_q    <= '0;
      mulOp_q  <= '0;
      mulCnt_q <= '0;
      divRem_q <= 1'b0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
    end else if (rdy_in) begin
      ready  <= 1'b0;
      rob_id <= '0;
      value  <= '0;
      if (clear) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (issue_valid) begin
              rob_q <= rob_dep;
              if (!op[2]) begin
                mulOp_q  <= op[1:0];
                lhs_q    <= lhs;
                rhs_q    <= rhs;
                mulCnt_q <= MCW'(MUL_STAGES - 1);
                state_q  <= ST_MUL;
              end else if (divZero || divOvf) begin
                res_q   <= specialVal;
                state_q <= ST_FIX;
              end else begin
                divRem_q <= isRemOp(op);
                negQ_q   <= lhsNeg ^ rhsNeg;
                negR_q   <= lhsNeg;
                state_q  <= ST_DIV;
              end
            end
          end
          ST_MUL: begin
            if (mulCnt_q == '0) begin
              ready   <= 1'b1;
              rob_id  <= rob_q;
              value   <= mulResult;
              state_q <= ST_IDLE;
            end else begin
              mulCnt_q <= mulCnt_q - MCW'(1);
            end
          end
          ST_DIV: begin
            if (divDone) begin
              res_q   <= divResult;
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            ready   <= 1'b1;
            rob_id  <= rob_q;
            value   <= res_q;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=2). Expected
// results and latencies come from a plain-arithmetic model of the RV32M
// rules; stimulus is a directed set followed by randomized ops.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int RW   = `ROB_WIDTH;
  localparam int MULS = 2;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic            clk_in;
  logic            rst_in;
  logic            rdy_in;
  logic            clear;
  logic            issue_valid;
  logic            issue_ready;
  logic [XLEN-1:0] lhs;
  logic [XLEN-1:0] rhs;
  logic [2:0]      op;
  logic [RW-1:0]   rob_dep;
  logic            ready;
  logic [RW-1:0]   rob_id;
  logic [XLEN-1:0] value;

  int checkCount = 0;
  int passCount  = 0;
  int strayCount = 0;

  muldiv_unit #(
    .XLEN       (XLEN),
    .ROB_WIDTH  (RW),
    .MUL_STAGES (MULS)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear       (clear),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .lhs         (lhs),
    .rhs         (rhs),
    .op          (op),
    .rob_dep     (rob_dep),
    .ready       (ready),
    .rob_id      (rob_id),
    .value       (value)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Tag 9 is only ever used by the op that gets flushed, so any result
  // carrying it is a result that should never have been produced.
  always @(posedge clk_in) begin
    #1;
    if (ready && rob_id == RW'(9)) strayCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Architectural result of one RV32M op, straight from the ISA rules.
  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (f)
      F_MUL:    begin p = sa * sb; r = p[31:0];  end
      F_MULH:   begin p = sa * sb; r = p[63:32]; end
      F_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F_MULHU:  begin p = ua * ub; r = p[63:32]; end
      F_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      F_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signedDiv;
    signedDiv = (f == F_DIV) || (f == F_REM);
    if (f < F_DIV) return MULS;
    if (b == 0) return 1;
    if (signedDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one op right now (caller is away from a clock edge with the unit
  // idle), optionally drop rdy_in for 'stall' cycles after acceptance, then
  // wait for the result pulse and check it. Returns #1 after the ready edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [RW-1:0] tag, input int stall);
    logic [31:0] expVal;
    int expLat;
    int lat;
    bit got;
    expVal = refResult(f, a, b);
    expLat = refLatency(f, a, b) + stall;
    checkOutput("issue_ready_idle", issue_ready, 1);
    op = f; lhs = a; rhs = b; rob_dep = tag; issue_valid = 1'b1;
    @(posedge clk_in);
    #1;
    issue_valid = 1'b0;
    lat = 0;
    got = 0;
    if (stall > 0) begin
      rdy_in = 1'b0;
      repeat (stall) @(posedge clk_in);
      #1;
      rdy_in = 1'b1;
      lat = stall;
      checkOutput("stall_no_ready", ready, 0);
    end
    while (!got && lat < 100) begin
      @(posedge clk_in);
      #1;
      lat++;
      if (lat == expLat - 1) checkOutput("busy_issue_ready", issue_ready, 0);
      if (ready) got = 1;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("value", value, expVal);
    checkOutput("rob_id", rob_id, tag);
  endtask

  task automatic checkPulseEnd();
    @(posedge clk_in);
    #1;
    checkOutput("pulse_end_ready", ready, 0);
    checkOutput("pulse_end_value", value, 0);
    checkOutput("pulse_end_rob_id", rob_id, 0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    op = '0; lhs = '0; rhs = '0; rob_dep = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_value", value, 0);
    checkOutput("rst_rob_id", rob_id, 0);
    checkOutput("rst_issue_ready", issue_ready, 1);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Multiplies
    applyStimulus(F_MUL, 32'd7, 32'hFFFF_FFFD, RW'(5), 0);
    checkPulseEnd();
    applyStimulus(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, RW'(6), 0);
    applyStimulus(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, RW'(7), 0);
    applyStimulus(F_MULH, 32'h8000_0000, 32'h8000_0000, RW'(1), 0);

    // Regular divides, back to back
    applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'd2, RW'(1), 0);
    applyStimulus(F_REM, 32'hFFFF_FFF9, 32'd2, RW'(2), 0);
    applyStimulus(F_DIVU, 32'd100, 32'd7, RW'(3), 0);
    applyStimulus(F_REMU, 32'd100, 32'd7, RW'(4), 0);

    // Special cases
    applyStimulus(F_DIV, 32'd5, 32'd0, RW'(5), 0);
    applyStimulus(F_REMU, 32'd5, 32'd0, RW'(6), 0);
    applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, RW'(7), 0);
    applyStimulus(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, RW'(0), 0);
    checkPulseEnd();

    // Flush 10 edges into a divide, then a fresh multiply
    op = F_DIV; lhs = 32'd1000; rhs = 32'd3; rob_dep = RW'(9); issue_valid = 1'b1;
    @(posedge clk_in);
    #1;
    issue_valid = 1'b0;
    repeat (9) @(posedge clk_in);
    #1;
    clear = 1'b1;
    @(posedge clk_in);
    #1;
    clear = 1'b0;
    checkOutput("clear_ready", ready, 0);
    checkOutput("clear_issue_ready", issue_ready, 1);
    applyStimulus(F_MUL, 32'd6, 32'd7, RW'(10), 0);
    checkPulseEnd();

    // rdy_in stall during a multiply, then issue in the ready cycle
    applyStimulus(F_MUL, 32'd12345, 32'd678, RW'(3), 4);
    applyStimulus(F_MUL, 32'hDEAD_BEEF, 32'd3, RW'(4), 0);
    checkPulseEnd();

    // Asynchronous reset in the middle of a divide
    op = F_DIVU; lhs = 32'd99999; rhs = 32'd13; rob_dep = RW'(2); issue_valid = 1'b1;
    @(posedge clk_in);
    #1;
    issue_valid = 1'b0;
    repeat (5) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_value", value, 0);
    checkOutput("midrst_issue_ready", issue_ready, 1);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    checkOutput("postrst_ready", ready, 0);

    // Randomized ops with occasional special operands and stalls
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int sel, stall;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) begin a = 32'($urandom_range(0, 255)); b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7)); end
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(f, a, b, RW'($urandom_range(0, 7)), stall);
    end
    checkPulseEnd();

    repeat (5) @(posedge clk_in);
    #1;
    checkOutput("flushed_tag_never_returned", strayCount, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
